// File: rtl/frng_link_responder.sv
// Fringe ring responder link: buffers the wen token in a small FIFO and forwards it.
// Token toggle statistics exist only when FRNG_LINK_STATS_EN is defined.
module frng_link_responder #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 32,
  parameter int LINK_ID = 0
) (
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic [CNT_W-1:0] token_cnt,
  output logic [CNT_W-1:0] last_period,
  output logic             benchmark_event,
  output logic [31:0]      link_id
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full      = (occ == (PTR_W+1)'(DEPTH));
  assign empty     = (occ == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  // Gating keeps out_bit at 0 whenever no entry is held, including out of reset.
  assign out_bit   = out_valid & mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign link_id   = 32'(LINK_ID);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= in_bit;
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef FRNG_LINK_STATS_EN
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic             last_bit;
  logic             toggle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign toggle = pop && (out_bit != last_bit);

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      clk_cnt         <= '0;
      last_bit        <= 1'b0;
      token_cnt       <= '0;
      last_period     <= '0;
      benchmark_event <= 1'b0;
    end else begin
      benchmark_event <= toggle;
      if (pop) last_bit <= out_bit;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          if (toggle) begin
            state     <= ST_RUN;
            token_cnt <= CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (toggle) begin
            last_period <= sat_inc(clk_cnt);
            clk_cnt     <= '0;
            token_cnt   <= token_cnt + CNT_W'(1);
          end else begin
            clk_cnt <= sat_inc(clk_cnt);
          end
        end
      endcase
    end
  end
`else
  assign token_cnt       = '0;
  assign last_period     = '0;
  assign benchmark_event = 1'b0;
`endif

endmodule

// File: tb/tb_frng_link_responder.sv
// Randomised and directed bench for frng_link_responder against a queue-based reference model.
`timescale 1ns/1ps
module tb_frng_link_responder;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 32;
  localparam int LINK_ID = 7;

`ifdef FRNG_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_ready;
  logic [CNT_W-1:0] token_cnt;
  logic [CNT_W-1:0] last_period;
  logic             benchmark_event;
  logic [31:0]      link_id;

  always #5 i_clk = ~i_clk;

  frng_link_responder #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .LINK_ID (LINK_ID)
  ) dut (
    .i_clk           (i_clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_bit          (in_bit),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_bit         (out_bit),
    .out_ready       (out_ready),
    .token_cnt       (token_cnt),
    .last_period     (last_period),
    .benchmark_event (benchmark_event),
    .link_id         (link_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: token queue plus toggle bookkeeping by absolute cycle number.
  bit          q[$];
  bit          m_last;
  bit          m_started;
  bit          m_ev;
  int          m_cyc;
  int          m_tog_cyc;
  int unsigned m_tok;
  int unsigned m_per;

  function automatic void model_reset();
    q.delete();
    m_last    = 1'b0;
    m_started = 1'b0;
    m_ev      = 1'b0;
    m_cyc     = 0;
    m_tog_cyc = 0;
    m_tok     = 0;
    m_per     = 0;
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, (q.size() < DEPTH) ? 1 : 0);
    chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) chk("out_bit", out_bit, q[0]);
    chk("token_cnt", token_cnt, STATS ? m_tok : 0);
    chk("last_period", last_period, STATS ? m_per : 0);
    chk("benchmark_event", benchmark_event, STATS ? m_ev : 0);
  endtask

  task automatic step(input bit iv, input bit ib, input bit ordy);
    bit do_push;
    bit do_pop;
    bit b;
    in_valid  = iv;
    in_bit    = ib;
    out_ready = ordy;
    do_push   = iv && (q.size() < DEPTH);
    do_pop    = ordy && (q.size() > 0);
    @(posedge i_clk);
    #1;
    m_cyc++;
    m_ev = 1'b0;
    if (do_pop) begin
      b = q.pop_front();
      if (b != m_last) begin
        m_ev = 1'b1;
        if (m_started) m_per = m_cyc - m_tog_cyc;
        m_started = 1'b1;
        m_tok++;
        m_tog_cyc = m_cyc;
      end
      m_last = b;
    end
    if (do_push) q.push_back(ib);
    check_all();
  endtask

  // Asserted between edges so the first check sees whether clearing is asynchronous.
  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge i_clk);
    #1;
    check_all();
    @(negedge i_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit exp_bits[4];
    int ev_cnt;

    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    do_reset();
    chk("link_id", link_id, LINK_ID);

    // Fill with out_ready low, then drain in order.
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) step(1'b1, exp_bits[i], 1'b0);
    chk("fill_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_bit", out_bit, exp_bits[i]);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("drain_empty", out_valid, 0);

    // Full with both sides active: pop only.
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("full_pop_no_push", in_ready, 1);

    // Settle at occupancy 2, then simultaneous push/pop for 10 cycles.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      chk("occ2_stable", (q.size() == 2) ? 1 : 0, 1);
    end

    // Toggle period scenario.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step((c == 0) || (c == 5) || (c == 8), (c == 0) || (c == 8), 1'b1);
      if (c == 6) chk("period_first", last_period, STATS ? 5 : 0);
    end
    chk("period_tok", token_cnt, STATS ? 3 : 0);
    chk("period_second", last_period, STATS ? 3 : 0);

    // Repeated value: only the first pop toggles.
    do_reset();
    ev_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(c < 3, 1'b1, 1'b1);
      if (benchmark_event) ev_cnt++;
    end
    chk("repeat_tok", token_cnt, STATS ? 1 : 0);
    chk("repeat_events", ev_cnt, STATS ? 1 : 0);

    // Back-to-back toggles, then a reset in the middle of traffic.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'(c % 2 == 0), 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1);
    chk("b2b_period", last_period, STATS ? 1 : 0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'(c), 1'b0);
    do_reset();

    // Randomised traffic with varying pressure on each side.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2 + (c / 100) % 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
